// File: rtl/aer_arb_addr_enc_if.sv
// AER readout bus: pixel req/ack lines plus the encoded-address valid/ready stream.
// The encoder side uses the master modport; the pixel array and serializer side uses slave.
interface aer_arb_addr_enc_if #(
   parameter int unsigned N  = 12,
   parameter int unsigned AW = 4,
   parameter int unsigned CW = 8
) ();
   logic [N-1:0]  req;
   logic [N-1:0]  ack;
   logic [AW-1:0] addr;
   logic          valid;
   logic          ready;
   logic          busy;
   logic [CW-1:0] coll_cnt;

   modport master (
      input  req, ready,
      output ack, addr, valid, busy, coll_cnt
   );

   modport slave (
      output req, ready,
      input  ack, addr, valid, busy, coll_cnt
   );
endinterface

// File: rtl/aer_arb_addr_enc.sv
// AER row/column readout: arbitrates N request lines, streams the winner's address on valid/ready
// and completes a 4-phase req/ack handshake with the granted pixel.
module aer_arb_addr_enc #(
   parameter int unsigned N       = 12,
   parameter int unsigned AW      = 4,
   parameter int unsigned RR_MODE = 0,
   parameter int unsigned CW      = 8
) (
   input logic                i_clk,
   input logic                i_rst,
   aer_arb_addr_enc_if.master bus
);

   typedef enum logic [1:0] {StIdle, StSend, StRelease} state_e;

   state_e        r_state, w_state_d;
   logic [AW-1:0] r_addr, w_addr_d;
   logic          r_valid, w_valid_d;
   logic [N-1:0]  r_ack, w_ack_d;
   logic [AW-1:0] r_rr_ptr, w_rr_ptr_d;
   logic [CW-1:0] r_coll, w_coll_d;

   logic [N-1:0]  w_hi_mask;
   logic [N-1:0]  w_req_hi;
   logic [N-1:0]  w_onehot;
   logic [AW-1:0] w_pick;
   logic          w_multi;
   logic          w_req_granted;

   function automatic logic [AW-1:0] lowest_set(input logic [N-1:0] v);
      logic [AW-1:0] idx;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) idx = AW'(i);
      end
      return idx;
   endfunction

   // Round-robin: prefer lines above rr_ptr, otherwise wrap to the lowest line (rr_ptr last).
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_hi_mask[i] = (AW'(i) > r_rr_ptr);
         w_onehot[i]  = (r_addr == AW'(i));
      end
      w_req_hi = bus.req & w_hi_mask;
      if ((RR_MODE != 0) && (|w_req_hi)) w_pick = lowest_set(w_req_hi);
      else                               w_pick = lowest_set(bus.req);
      w_multi       = |(bus.req & (bus.req - N'(1)));
      w_req_granted = |(bus.req & r_ack);
   end

   always_comb begin
      w_state_d  = r_state;
      w_addr_d   = r_addr;
      w_valid_d  = r_valid;
      w_ack_d    = r_ack;
      w_rr_ptr_d = r_rr_ptr;
      w_coll_d   = r_coll;
      unique case (r_state)
         StIdle: begin
            if (|bus.req) begin
               w_addr_d  = w_pick;
               w_valid_d = 1'b1;
               w_state_d = StSend;
               if (w_multi && (r_coll != '1)) w_coll_d = r_coll + CW'(1);
            end
         end
         StSend: begin
            if (r_valid && bus.ready) begin
               w_valid_d = 1'b0;
               w_ack_d   = w_onehot;
               w_state_d = StRelease;
            end
         end
         StRelease: begin
            if (!w_req_granted) begin
               w_ack_d   = '0;
               w_state_d = StIdle;
               if (RR_MODE != 0) w_rr_ptr_d = r_addr;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_addr   <= '0;
         r_valid  <= 1'b0;
         r_ack    <= '0;
         r_rr_ptr <= AW'(N - 1);
         r_coll   <= '0;
      end else begin
         r_state  <= w_state_d;
         r_addr   <= w_addr_d;
         r_valid  <= w_valid_d;
         r_ack    <= w_ack_d;
         r_rr_ptr <= w_rr_ptr_d;
         r_coll   <= w_coll_d;
      end
   end

   assign bus.ack      = r_ack;
   assign bus.addr     = r_addr;
   assign bus.valid    = r_valid;
   assign bus.busy     = (r_state != StIdle);
   assign bus.coll_cnt = r_coll;

endmodule

// File: tb/tb_aer_arb_addr_enc.sv
// Scoreboard bench for aer_arb_addr_enc: fixed-priority, round-robin and 64-line instances
// driven by a shared pixel model; expected addresses are queued at stimulus time.
module tb_aer_arb_addr_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [63:0] r_req;
   int          sel;
   logic        auto_drop;
   logic        reassert;
   logic [63:0] pend;

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;
   int vld_cnt  = 0;
   int ack_cnt  = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   aer_arb_addr_enc_if #(.N(12), .AW(4), .CW(8)) if_f ();
   aer_arb_addr_enc_if #(.N(12), .AW(4), .CW(8)) if_r ();
   aer_arb_addr_enc_if #(.N(64), .AW(6), .CW(8)) if_w ();

   assign if_f.req   = (sel == 0) ? r_req[11:0] : 12'h0;
   assign if_r.req   = (sel == 1) ? r_req[11:0] : 12'h0;
   assign if_w.req   = (sel == 2) ? r_req : 64'h0;
   assign if_f.ready = ready;
   assign if_r.ready = ready;
   assign if_w.ready = ready;

   aer_arb_addr_enc #(.N(12), .AW(4), .RR_MODE(0), .CW(8)) u_fix (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if_f)
   );
   aer_arb_addr_enc #(.N(12), .AW(4), .RR_MODE(1), .CW(8)) u_rr (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if_r)
   );
   aer_arb_addr_enc #(.N(64), .AW(6), .RR_MODE(0), .CW(8)) u_wide (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if_w)
   );

   logic [63:0] mon_ack;
   logic [5:0]  mon_addr;
   logic        mon_valid;
   logic        mon_busy;
   logic [7:0]  mon_coll;

   always_comb begin
      mon_ack = '0; mon_addr = '0; mon_valid = 1'b0; mon_busy = 1'b0; mon_coll = '0;
      case (sel)
         0: begin
            mon_ack = 64'(if_f.ack); mon_addr = 6'(if_f.addr); mon_valid = if_f.valid;
            mon_busy = if_f.busy; mon_coll = if_f.coll_cnt;
         end
         1: begin
            mon_ack = 64'(if_r.ack); mon_addr = 6'(if_r.addr); mon_valid = if_r.valid;
            mon_busy = if_r.busy; mon_coll = if_r.coll_cnt;
         end
         default: begin
            mon_ack = if_w.ack; mon_addr = if_w.addr; mon_valid = if_w.valid;
            mon_busy = if_w.busy; mon_coll = if_w.coll_cnt;
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pops(input int target, input int budget);
      int n = 0;
      while (n_pops < target && n < budget) begin
         step();
         n++;
      end
      check("pops_timeout", 64'(n_pops >= target), 64'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((mon_busy || mon_ack != 0 || r_req != 0) && n < 200) begin
         step();
         n++;
      end
      check("idle_timeout", 64'(n < 200), 64'd1);
   endtask

   task automatic wait_ack(input logic [63:0] mask);
      int n = 0;
      while ((mon_ack & mask) == 0 && n < 50) begin
         step();
         n++;
      end
      check("ack_timeout", 64'((mon_ack & mask) != 0), 64'd1);
   endtask

   // Monitor: pop an expected address on every valid&ready handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (mon_valid) vld_cnt++;
         if (mon_ack != 0) begin
            ack_cnt++;
            check("ack_onehot", 64'($onehot(mon_ack)), 64'd1);
         end
         if (mon_valid && ready) begin
            n_pops++;
            if (exp_q.size() == 0) check("sb_unexpected_grant", 64'(mon_addr), '1);
            else                   check("sb_addr", 64'(mon_addr), 64'(exp_q.pop_front()));
            check("ack_during_send", mon_ack, 64'd0);
         end
      end
   end

   // Pixel model: drop req on ack, optionally re-raise once ack has fallen.
   always @(negedge clk) begin
      if (auto_drop && (mon_ack & r_req) != 0) begin
         if (reassert) pend = pend | mon_ack;
         r_req = r_req & ~mon_ack;
      end else if (reassert && mon_ack == 0 && pend != 0) begin
         r_req = r_req | pend;
         pend  = '0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst = 1'b1; ready = 1'b1; r_req = '0; sel = 0;
      auto_drop = 1'b0; reassert = 1'b0; pend = '0;
      repeat (3) step();
      rst = 1'b0;

      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("rst_ack", mon_ack, 64'd0);
         check("rst_valid", 64'(mon_valid), 64'd0);
         check("rst_busy", 64'(mon_busy), 64'd0);
         check("rst_addr", 64'(mon_addr), 64'd0);
         check("rst_coll", 64'(mon_coll), 64'd0);
      end

      // Single request, immediate ready.
      sel = 0; vld_cnt = 0; ack_cnt = 0; auto_drop = 1'b1;
      base = n_pops;
      exp_q.push_back(4);
      r_req = 64'h010;
      wait_pops(base + 1, 50);
      wait_idle();
      check("t1_valid_cycles", 64'(vld_cnt), 64'd1);
      check("t1_ack_cycles", 64'(ack_cnt), 64'd1);
      check("t1_coll", 64'(mon_coll), 64'd0);

      // Fixed priority with collisions.
      base = n_pops;
      exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(11);
      r_req = 64'h881;
      wait_pops(base + 3, 100);
      wait_idle();
      check("t2_coll", 64'(mon_coll), 64'd2);

      // Round-robin, all lines re-raised after each ack; counter saturates.
      sel = 1; reassert = 1'b1; pend = '0;
      base = n_pops;
      for (int i = 0; i < 260; i++) exp_q.push_back(i % 12);
      r_req = 64'hFFF;
      wait_pops(base + 13, 200);
      check("t3_coll_mid", 64'(mon_coll), 64'd13);
      wait_pops(base + 260, 3000);
      r_req = '0; reassert = 1'b0; pend = '0;
      wait_idle();
      check("t3_coll_sat", 64'(mon_coll), 64'd255);

      // Backpressure.
      sel = 0; ready = 1'b0;
      base = n_pops;
      exp_q.push_back(2);
      r_req = 64'h004;
      repeat (10) step();
      check("t4_valid_held", 64'(mon_valid), 64'd1);
      check("t4_addr_held", 64'(mon_addr), 64'd2);
      check("t4_no_ack", mon_ack, 64'd0);
      check("t4_busy", 64'(mon_busy), 64'd1);
      ready = 1'b1;
      step();
      check("t4_ack", mon_ack, 64'h004);
      wait_idle();

      // Reset while in RELEASE drops the event and restarts the RR search at 0.
      sel = 1; auto_drop = 1'b0;
      exp_q.push_back(5);
      r_req = 64'h020;
      wait_ack(64'h020);
      step();
      check("t5_ack_held", mon_ack, 64'h020);
      check("t5_busy", 64'(mon_busy), 64'd1);
      rst = 1'b1; r_req = '0;
      step();
      rst = 1'b0;
      check("t5_rst_ack", mon_ack, 64'd0);
      check("t5_rst_valid", 64'(mon_valid), 64'd0);
      check("t5_rst_busy", 64'(mon_busy), 64'd0);
      check("t5_rst_coll", 64'(mon_coll), 64'd0);
      auto_drop = 1'b1;
      base = n_pops;
      exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(11);
      r_req = 64'h821;
      wait_pops(base + 3, 100);
      wait_idle();

      // 64 lines: top line granted; lines raised during RELEASE wait for IDLE.
      sel = 2; auto_drop = 1'b0;
      base = n_pops;
      exp_q.push_back(63); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      r_req = 64'h8000_0000_0000_0000;
      wait_ack(64'h8000_0000_0000_0000);
      r_req = r_req | 64'h7;
      repeat (3) step();
      check("t6_ack_held", mon_ack, 64'h8000_0000_0000_0000);
      check("t6_addr", 64'(mon_addr), 64'd63);
      check("t6_valid", 64'(mon_valid), 64'd0);
      auto_drop = 1'b1;
      wait_pops(base + 4, 100);
      wait_idle();
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
